mem_port_arbiter: RTL and testbench

- Shares the core's single memory port between instruction fetch and the Mem-stage data access.
- Generates the `i_arready` and `d_mem_ready` handshakes consumed by the hazard unit's fetch and memory wait-stall logic.
- Data requests have priority, bounded by an anti-starvation counter so fetch always makes progress.
- One outstanding transaction at a time; responses are routed back to the requester that issued the transaction.

---
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the core's single memory port between
// instruction fetch and Mem-stage data access, one transaction at a time.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   i_arvalid_i/i_araddr_i       fetch request (held until i_arready_o)
//   i_arready_o                  fetch request accepted this cycle
//   i_rvalid_o/i_rdata_o         fetch read data, one-cycle pulse
//   d_req_i/d_we_i/d_be_i        data request, store flag, byte enables
//   d_addr_i/d_wdata_i           data address and store data
//   d_ready_o                    data request accepted this cycle
//   d_rvalid_o/d_rdata_o         load data or store ack, one-cycle pulse
//   m_req_o/m_we_o/m_be_o        registered memory request
//   m_addr_o/m_wdata_o           registered memory address / store data
//   m_gnt_i                      memory accepted m_req_o this cycle
//   m_rvalid_i/m_rdata_i         memory response
//   busy_o                       a transaction is in flight
//   err_o                        pulse on a response nobody asked for

module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                i_arvalid_i,
  input  logic [ADDR_W-1:0]   i_araddr_i,
  output logic                i_arready_o,
  output logic                i_rvalid_o,
  output logic [DATA_W-1:0]   i_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_ready_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                m_req_o,
  output logic                m_we_o,
  output logic [DATA_W/8-1:0] m_be_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  input  logic                m_gnt_i,
  input  logic                m_rvalid_i,
  input  logic [DATA_W-1:0]   m_rdata_i,
  output logic                busy_o,
  output logic                err_o
);

  localparam int         BE_W  = DATA_W / 8;
  localparam logic [3:0] L_MAX = 4'(MAX_D_STREAK);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_I,
    S_REQ_D,
    S_RSP_I,
    S_RSP_D
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_streak;
  logic [3:0]        w_streak_nxt;

  logic              r_m_req;
  logic              r_m_we;
  logic [BE_W-1:0]   r_m_be;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;

  logic              w_idle;
  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_rsp_i;
  logic              w_rsp_d;
  logic              w_err;

  // Handshake outputs are masked while rst_i is high so that a
  // response racing the reset is never forwarded.
  always_comb begin
    w_idle    = !rst_i && (r_state == S_IDLE);
    w_grant_i = w_idle && i_arvalid_i &&
                (!d_req_i || (r_streak == L_MAX));
    w_grant_d = w_idle && d_req_i && !w_grant_i;
    w_rsp_i   = !rst_i && m_rvalid_i && (r_state == S_RSP_I);
    w_rsp_d   = !rst_i && m_rvalid_i && (r_state == S_RSP_D);
    w_err     = !rst_i && m_rvalid_i &&
                (r_state inside {S_IDLE, S_REQ_I, S_REQ_D});
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        unique case (1'b1)
          w_grant_i: w_state_nxt = S_REQ_I;
          w_grant_d: w_state_nxt = S_REQ_D;
          default:   w_state_nxt = S_IDLE;
        endcase
      end
      S_REQ_I: if (m_gnt_i)    w_state_nxt = S_RSP_I;
      S_REQ_D: if (m_gnt_i)    w_state_nxt = S_RSP_D;
      S_RSP_I: if (m_rvalid_i) w_state_nxt = S_IDLE;
      S_RSP_D: if (m_rvalid_i) w_state_nxt = S_IDLE;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  // The streak only counts data wins that actually kept a waiting
  // fetch out; any cycle without a pending fetch starts it over.
  always_comb begin
    w_streak_nxt = r_streak;
    if (w_idle) begin
      if (w_grant_i || !i_arvalid_i) begin
        w_streak_nxt = 4'd0;
      end else if (w_grant_d && (r_streak != L_MAX)) begin
        w_streak_nxt = r_streak + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_streak  <= 4'd0;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_be    <= '0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
      if (w_grant_i) begin
        r_m_req   <= 1'b1;
        r_m_we    <= 1'b0;
        r_m_be    <= '1;
        r_m_addr  <= i_araddr_i;
        r_m_wdata <= '0;
      end else if (w_grant_d) begin
        r_m_req   <= 1'b1;
        r_m_we    <= d_we_i;
        r_m_be    <= d_be_i;
        r_m_addr  <= d_addr_i;
        r_m_wdata <= d_wdata_i;
      end else if (r_m_req && m_gnt_i) begin
        r_m_req   <= 1'b0;
      end
    end
  end

  assign i_arready_o = w_grant_i;
  assign d_ready_o   = w_grant_d;
  assign i_rvalid_o  = w_rsp_i;
  assign d_rvalid_o  = w_rsp_d;
  assign i_rdata_o   = w_rsp_i ? m_rdata_i : '0;
  assign d_rdata_o   = w_rsp_d ? m_rdata_i : '0;

  assign m_req_o   = r_m_req;
  assign m_we_o    = r_m_we;
  assign m_be_o    = r_m_be;
  assign m_addr_o  = r_m_addr;
  assign m_wdata_o = r_m_wdata;

  assign busy_o = (r_state != S_IDLE);
  assign err_o  = w_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a
// randomized requester/memory environment and directed corner cases.

module tb_mem_port_arbiter;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        i_arvalid_i = 1'b0;
  logic [31:0] i_araddr_i = '0;
  logic        i_arready_o;
  logic        i_rvalid_o;
  logic [31:0] i_rdata_o;
  logic        d_req_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [3:0]  d_be_i = '0;
  logic [31:0] d_addr_i = '0;
  logic [31:0] d_wdata_i = '0;
  logic        d_ready_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        m_req_o;
  logic        m_we_o;
  logic [3:0]  m_be_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_wdata_o;
  logic        m_gnt_i = 1'b0;
  logic        m_rvalid_i = 1'b0;
  logic [31:0] m_rdata_i = '0;
  logic        busy_o;
  logic        err_o;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAXS)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .i_arvalid_i(i_arvalid_i), .i_araddr_i(i_araddr_i),
    .i_arready_o(i_arready_o), .i_rvalid_o(i_rvalid_o),
    .i_rdata_o(i_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i),
    .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_ready_o(d_ready_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_be_o(m_be_o),
    .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i),
    .m_rdata_i(m_rdata_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_d;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t exp_req[$];
  txn_t exp_rsp[$];
  byte  glog[$];

  int n_chk = 0;
  int n_pass = 0;

  // reference model state
  bit   m_idle = 1'b1;
  int   m_streak = 0;
  bit   mo_ei, mo_ed;
  txn_t mo_t;

  // environment knobs
  int          f_pct = 0, d_pct = 0, gnt_pct = 100;
  int          dmin = 1, dmax = 1;
  bit          man_f = 0, man_d = 0;
  logic [31:0] man_faddr, man_daddr, man_dwd;
  logic        man_dwe;
  logic [3:0]  man_dbe;
  bit          fix_rd = 0;
  logic [31:0] fix_val = '0;
  bit          i_acc = 0, d_acc = 0, g_seen = 0;
  int          cnt = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // One clock of environment: drive after the edge, sample at negedge.
  task automatic cycle();
    @(posedge clk); #1;
    if (m_rvalid_i) m_rvalid_i = 1'b0;
    if (g_seen) cnt = $urandom_range(dmax, dmin);
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        m_rvalid_i = 1'b1;
        m_rdata_i = fix_rd ? fix_val : $urandom;
      end
    end
    m_gnt_i = ($urandom_range(99, 0) < gnt_pct);
    if (i_acc) i_arvalid_i = 1'b0;
    if (d_acc) d_req_i = 1'b0;
    if (man_f) begin
      i_arvalid_i = 1'b1;
      i_araddr_i = man_faddr;
      man_f = 0;
    end else if (!i_arvalid_i && $urandom_range(99, 0) < f_pct) begin
      i_arvalid_i = 1'b1;
      i_araddr_i = $urandom & 32'hFFFF_FFFC;
    end
    if (man_d) begin
      d_req_i = 1'b1;
      d_we_i = man_dwe;
      d_be_i = man_dbe;
      d_addr_i = man_daddr;
      d_wdata_i = man_dwd;
      man_d = 0;
    end else if (!d_req_i && $urandom_range(99, 0) < d_pct) begin
      d_req_i = 1'b1;
      d_we_i = $urandom_range(1, 0);
      d_be_i = $urandom_range(15, 1);
      d_addr_i = $urandom;
      d_wdata_i = $urandom;
    end
    @(negedge clk);
    i_acc = i_arready_o;
    d_acc = d_ready_o;
    g_seen = m_req_o && m_gnt_i;
  endtask

  task automatic drain();
    int q = 0;
    f_pct = 0; d_pct = 0; gnt_pct = 100; dmin = 1; dmax = 3;
    for (int k = 0; k < 300 && q < 3; k++) begin
      cycle();
      if (!i_arvalid_i && !d_req_i && m_idle) q++;
      else q = 0;
    end
    chk("drain_busy", busy_o, 0);
    chk("drain_queues", exp_req.size() + exp_rsp.size(), 0);
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_ctl"}, {i_arready_o, i_rvalid_o, d_ready_o,
        d_rvalid_o, m_req_o, m_we_o, busy_o, err_o}, 0);
    chk({nm, "_mbe"}, m_be_o, 0);
    chk({nm, "_maddr"}, m_addr_o, 0);
    chk({nm, "_mwdata"}, m_wdata_o, 0);
    chk({nm, "_rdata"}, {i_rdata_o, d_rdata_o}, 0);
  endtask

  // Monitor and scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst_i) begin
      m_idle = 1;
      m_streak = 0;
      exp_req.delete();
      exp_rsp.delete();
    end else begin
      if (i_arready_o) glog.push_back("I");
      if (d_ready_o) glog.push_back("D");
      if (m_idle) begin
        mo_ei = i_arvalid_i && (!d_req_i || m_streak == MAXS);
        mo_ed = d_req_i && !mo_ei;
        if (i_arvalid_i || d_req_i || i_arready_o || d_ready_o) begin
          chk("arb_i", i_arready_o, mo_ei);
          chk("arb_d", d_ready_o, mo_ed);
        end
        if (!i_arvalid_i || mo_ei) m_streak = 0;
        else if (mo_ed && m_streak < MAXS) m_streak++;
        if (mo_ei) begin
          mo_t = '{is_d: 1'b0, we: 1'b0, be: 4'hF,
                   addr: i_araddr_i, wdata: 32'h0};
          exp_req.push_back(mo_t);
          m_idle = 0;
        end else if (mo_ed) begin
          mo_t = '{is_d: 1'b1, we: d_we_i, be: d_be_i,
                   addr: d_addr_i, wdata: d_wdata_i};
          exp_req.push_back(mo_t);
          m_idle = 0;
        end
      end else if (i_arready_o || d_ready_o) begin
        chk("ready_busy", {i_arready_o, d_ready_o}, 0);
      end
      if (m_req_o && m_gnt_i) begin
        if (exp_req.size() == 0) begin
          chk("gnt_unexp", m_req_o, 0);
        end else begin
          mo_t = exp_req.pop_front();
          chk("m_addr", m_addr_o, mo_t.addr);
          chk("m_we", m_we_o, mo_t.we);
          chk("m_be", m_be_o, mo_t.be);
          if (mo_t.we) chk("m_wdata", m_wdata_o, mo_t.wdata);
          exp_rsp.push_back(mo_t);
        end
      end
      if (m_rvalid_i && exp_rsp.size() > 0) begin
        mo_t = exp_rsp.pop_front();
        chk("i_rvalid", i_rvalid_o, !mo_t.is_d);
        chk("d_rvalid", d_rvalid_o, mo_t.is_d);
        if (!mo_t.is_d) chk("i_rdata", i_rdata_o, m_rdata_i);
        else if (!mo_t.we) chk("d_rdata", d_rdata_o, m_rdata_i);
        chk("err_rsp", err_o, 0);
        m_idle = 1;
      end else if (m_rvalid_i) begin
        chk("err_unexp", err_o, 1);
        chk("rvalid_unexp", {i_rvalid_o, d_rvalid_o}, 0);
      end else if (err_o || i_rvalid_o || d_rvalid_o) begin
        chk("spurious", {err_o, i_rvalid_o, d_rvalid_o}, 0);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);

    // fetch only, minimum latency
    drain();
    dmin = 1; dmax = 1; fix_rd = 1; fix_val = 32'hDEADBEEF;
    man_faddr = 32'h100; man_f = 1;
    cycle();
    chk("fo_arready", i_arready_o, 1);
    chk("fo_dready", d_ready_o, 0);
    cycle();
    chk("fo_mreq", m_req_o, 1);
    chk("fo_maddr", m_addr_o, 32'h100);
    chk("fo_mwe_be", {m_we_o, m_be_o}, 5'h0F);
    chk("fo_dready1", d_ready_o, 0);
    cycle();
    chk("fo_rvalid", i_rvalid_o, 1);
    chk("fo_rdata", i_rdata_o, 32'hDEADBEEF);
    chk("fo_mreq_drop", {m_req_o, d_ready_o}, 0);
    cycle();
    chk("fo_idle", busy_o, 0);
    fix_rd = 0;

    // collision: data store wins, fetch follows
    drain();
    dmin = 1; dmax = 1;
    man_faddr = 32'h180; man_f = 1;
    man_dwe = 1; man_dbe = 4'h1; man_daddr = 32'h200;
    man_dwd = 32'h55; man_d = 1;
    cycle();
    chk("col_dready", {d_ready_o, i_arready_o}, 2'b10);
    cycle();
    chk("col_m", {m_req_o, m_we_o, m_be_o}, 6'b11_0001);
    chk("col_maddr", m_addr_o, 32'h200);
    chk("col_mwdata", m_wdata_o, 32'h55);
    cycle();
    chk("col_ack", d_rvalid_o, 1);
    cycle();
    chk("col_fetch", i_arready_o, 1);

    // grant backpressure in REQ_D with a fetch waiting
    drain();
    gnt_pct = 0;
    man_dwe = 0; man_dbe = 4'hF; man_daddr = 32'h300;
    man_dwd = 32'h0; man_d = 1;
    man_faddr = 32'h380; man_f = 1;
    cycle();
    chk("bp_dready", d_ready_o, 1);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_mreq", {m_req_o, m_we_o, m_be_o}, 6'b10_1111);
      chk("bp_maddr", m_addr_o, 32'h300);
      chk("bp_busy", busy_o, 1);
      chk("bp_ready", {i_arready_o, d_ready_o}, 0);
    end
    gnt_pct = 100;

    // starvation bound under continuous requests
    drain();
    glog.delete();
    f_pct = 100; d_pct = 100; gnt_pct = 100; dmin = 1; dmax = 1;
    for (int k = 0; k < 200 && glog.size() < 10; k++) cycle();
    for (int k = 0; k < 10; k++) begin
      chk("starve_seq", (k < glog.size()) ? glog[k] : 8'h0,
          (k % (MAXS + 1) == MAXS) ? 8'h49 : 8'h44);
    end

    // randomized traffic, light and heavy
    drain();
    f_pct = 30; d_pct = 30; gnt_pct = 60; dmin = 1; dmax = 3;
    repeat (1500) cycle();
    drain();
    f_pct = 90; d_pct = 90; gnt_pct = 80; dmin = 1; dmax = 4;
    repeat (1500) cycle();

    // reset while in RSP_I, response arrives after release
    drain();
    dmin = 8; dmax = 8;
    man_faddr = 32'h400; man_f = 1;
    cycle();
    chk("rs_arready", i_arready_o, 1);
    cycle();
    cycle();
    chk("rs_busy", busy_o, 1);
    @(posedge clk); #1;
    rst_i = 1'b1;
    cnt = 0; m_rvalid_i = 0; m_gnt_i = 0;
    i_arvalid_i = 0; d_req_i = 0;
    i_acc = 0; d_acc = 0; g_seen = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_zero("rs_reset");
    @(posedge clk); #1;
    rst_i = 1'b0;
    m_rvalid_i = 1'b1;
    m_rdata_i = 32'h1234_5678;
    @(negedge clk);
    chk("rs_rvalid", {i_rvalid_o, d_rvalid_o}, 0);
    chk("rs_rdata", i_rdata_o, 0);
    chk("rs_err", err_o, 1);
    chk("rs_busy0", busy_o, 0);
    @(posedge clk); #1;
    m_rvalid_i = 1'b0;
    @(negedge clk);
    chk("rs_err_once", err_o, 0);

    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
